// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the command source / result consumer / ALU and the op sequencer.
// master = surrounding system (command source, result sink, combinational ALU); slave = sequencer.
interface alu_op_sequencer_if;
  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid holds, with its payload stable, until that edge.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_operand;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_cin;
  logic [3:0] alu_res;
  logic       alu_cout;
  logic       alu_of;

  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_c;
  logic       res_v;
  logic       res_z;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, res_ready, alu_res, alu_cout, alu_of,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_cin,
    input  res_valid, res_data, res_c, res_v, res_z, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, res_ready, alu_res, alu_cout, alu_of,
    output cmd_ready, alu_a, alu_b, alu_op, alu_cin,
    output res_valid, res_data, res_c, res_v, res_z, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the 4-bit ALU: accepts one command, drives the ALU from the
// accumulator, captures result and flags, and returns them over a result handshake.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADC  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b1111;

  state_t     state;
  logic [3:0] acc;
  logic       c_flag;
  logic       v_flag;
  logic       z_flag;
  logic       arith_q;
  logic [3:0] settle_cnt;

  logic       is_alu_op;
  logic       is_arith_op;
  logic       cap_c;
  logic       cap_v;
  logic       cap_z;

  assign is_alu_op   = (bus.cmd_op != OP_NOP) && (bus.cmd_op <= 4'd8);
  assign is_arith_op = (bus.cmd_op != OP_NOP) && (bus.cmd_op <= 4'd3);

  // Only the arithmetic ops report carry/overflow; logic ops clear both.
  assign cap_c = arith_q ? bus.alu_cout : 1'b0;
  assign cap_v = arith_q ? bus.alu_of   : 1'b0;
  assign cap_z = (bus.alu_res == 4'd0);

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= 4'd0;
      c_flag        <= 1'b0;
      v_flag        <= 1'b0;
      z_flag        <= 1'b0;
      arith_q       <= 1'b0;
      settle_cnt    <= 4'd0;
      bus.alu_a     <= 4'd0;
      bus.alu_b     <= 4'd0;
      bus.alu_op    <= 4'd0;
      bus.alu_cin   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= 4'd0;
      bus.res_c     <= 1'b0;
      bus.res_v     <= 1'b0;
      bus.res_z     <= 1'b0;
      bus.res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            arith_q <= is_arith_op;
            if (is_alu_op) begin
              bus.alu_a   <= acc;
              bus.alu_b   <= bus.cmd_operand;
              bus.alu_op  <= bus.cmd_op;
              bus.alu_cin <= (bus.cmd_op == OP_ADC) ? c_flag : 1'b0;
              settle_cnt  <= 4'(SETTLE_CYCLES - 1);
              state       <= DRIVE;
            end else begin
              // NOP, LOAD and illegal codes answer straight from the accumulator.
              bus.res_valid <= 1'b1;
              bus.res_data  <= acc;
              bus.res_c     <= c_flag;
              bus.res_v     <= v_flag;
              bus.res_z     <= z_flag;
              bus.res_err   <= 1'b0;
              if (bus.cmd_op == OP_LOAD) begin
                acc          <= bus.cmd_operand;
                z_flag       <= (bus.cmd_operand == 4'd0);
                bus.res_data <= bus.cmd_operand;
                bus.res_z    <= (bus.cmd_operand == 4'd0);
              end else if (bus.cmd_op != OP_NOP) begin
                bus.res_err <= 1'b1;
              end
              state <= RESP;
            end
          end
        end

        DRIVE: begin
          if (settle_cnt == 4'd0) begin
            acc           <= bus.alu_res;
            z_flag        <= cap_z;
            c_flag        <= cap_c;
            v_flag        <= cap_v;
            bus.res_valid <= 1'b1;
            bus.res_data  <= bus.alu_res;
            bus.res_c     <= cap_c;
            bus.res_v     <= cap_v;
            bus.res_z     <= cap_z;
            bus.res_err   <= 1'b0;
            bus.alu_a     <= 4'd0;
            bus.alu_b     <= 4'd0;
            bus.alu_op    <= 4'd0;
            bus.alu_cin   <= 1'b0;
            state         <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
